// File: rtl/cmp_arbiter.sv
// Round-robin arbiter in front of one shared unsigned greater-than comparator.
// Stage 1 holds the winning requester's captured operands. Stage 2 returns the
// registered result, which is tagged to that requester by a one-cycle ack.
module cmp_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    gt,
    output logic                    busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Registered state
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [NREQ-1:0]  inflight_q, inflight_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             gt_q, gt_d;
    logic             busy_q, busy_d;

    // Arbitration results
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  win_onehot;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic [PW:0]      cand;
    logic             cmp_gt;

    // Per-requester operand slices, unpacked for readability.
    logic [WIDTH-1:0] a_slice [NREQ];
    logic [WIDTH-1:0] b_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = a_in[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Unsigned A > B. The borrow out of the WIDTH+1-bit difference B - A is set
    // exactly when A exceeds B, so equal operands give 0.
    function automatic logic greater_than(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic [WIDTH:0] diff;
        diff = {1'b0, b} - {1'b0, a};
        return diff[WIDTH];
    endfunction

    assign cmp_gt = greater_than(op_a_q, op_b_q);

    // Round-robin search: start one past the last winner and wrap around.
    // Busy requesters are skipped.
    always_comb begin
        eligible   = req & ~inflight_q;
        win_found  = 1'b0;
        win_idx    = ptr_q;
        cand       = '0;
        win_onehot = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(off);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!win_found && eligible[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            win_onehot[i] = win_found && (win_idx == PW'(i));
        end
    end

    // Next-state for both pipeline stages, the pointer and the in-flight mask.
    always_comb begin
        gnt_d      = win_onehot;
        s1_valid_d = win_found;
        ptr_d      = win_found ? win_idx : ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                op_a_d = a_slice[i];
                op_b_d = b_slice[i];
            end
        end

        // A result retiring from stage 1 frees its requester.
        // A new winner marks itself busy.
        inflight_d = inflight_q;
        if (s1_valid_q) begin
            inflight_d = inflight_d & ~gnt_q;
        end
        inflight_d = inflight_d | win_onehot;

        s2_valid_d = s1_valid_q;
        ack_d      = s1_valid_q ? gnt_q : '0;
        gt_d       = s1_valid_q ? cmp_gt : gt_q;
        busy_d     = s1_valid_d | s2_valid_d;
    end

    // State registers. Reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q      <= '0;
            ack_q      <= '0;
            inflight_q <= '0;
            ptr_q      <= PW'(NREQ-1);
            op_a_q     <= '0;
            op_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            gt_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            inflight_q <= inflight_d;
            ptr_q      <= ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            gt_q       <= gt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign gt   = gt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with WIDTH=8 and NREQ=4.
// It runs a vector table first, then hand-written multi-cycle sequences.
module tb_cmp_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  gt;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .gnt  (gnt),
        .ack  (ack),
        .gt   (gt),
        .busy (busy)
    );

    // One row: inputs held for one cycle, then the outputs expected after that edge.
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        gt;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] r,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] eg, input logic [3:0] ea,
                                input logic egt, input logic eb);
        vec_t v;
        v.rst = rst; v.req = r; v.a = a; v.b = b;
        v.gnt = eg; v.ack = ea; v.gt = egt; v.busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gt is compared only where it carries meaning: on an ack, or right after reset.
    task automatic expect_outs(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                               input logic egt, input logic chk_gt, input logic eb);
        $display("%s: req=%b gnt=%b ack=%b gt=%b busy=%b", tag, req, gnt, ack, gt, busy);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".ack"}, 32'(ack), 32'(ea));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        if (chk_gt) check({tag, ".gt"}, 32'(gt), 32'(egt));
    endtask

    localparam logic [31:0] A_X = 32'h00FF2423; // A3=0   A2=255 A1=36 A0=35
    localparam logic [31:0] B_X = 32'hFF00240C; // B3=255 B2=0   B1=36 B0=12
    localparam logic [31:0] A_C = 32'h7F800901; // A3=127 A2=128 A1=9  A0=1
    localparam logic [31:0] B_C = 32'h807F0302; // B3=128 B2=127 B1=3  B0=2

    initial begin
        reset = 1'b1; req = '0; a_in = '0; b_in = '0;
        tick(); tick();
        expect_outs("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        // Single request, then equal and extreme operands on requesters 1..3.
        tbl.push_back(mk(0, 4'b0001, A_X, B_X, 4'b0001, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, A_X, B_X, 4'b0000, 4'b0001, 1, 1));
        tbl.push_back(mk(0, 4'b0000, A_X, B_X, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1110, A_X, B_X, 4'b0010, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b1100, A_X, B_X, 4'b0100, 4'b0010, 0, 1));
        tbl.push_back(mk(0, 4'b1000, A_X, B_X, 4'b1000, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 4'b0000, A_X, B_X, 4'b0000, 4'b1000, 0, 1));
        tbl.push_back(mk(0, 4'b0000, A_X, B_X, 4'b0000, 4'b0000, 0, 0));
        // Reset, then all four request continuously: strict rotation 0,1,2,3,0,1.
        tbl.push_back(mk(1, 4'b0000, A_C, B_C, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b0001, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b0010, 4'b0001, 0, 1));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b0100, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b1000, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b0001, 4'b1000, 0, 1));
        tbl.push_back(mk(0, 4'b1111, A_C, B_C, 4'b0010, 4'b0001, 0, 1));
        tbl.push_back(mk(0, 4'b0000, A_C, B_C, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 4'b0000, A_C, B_C, 4'b0000, 4'b0000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; req = tbl[i].req; a_in = tbl[i].a; b_in = tbl[i].b;
            tick();
            expect_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].gt,
                        tbl[i].rst || (tbl[i].ack != 4'b0000), tbl[i].busy);
        end
        reset = 1'b0;

        // Operand changed after the grant must not affect the result (10 > 100 is false).
        req = 4'b0100; a_in = 32'h000A_0000; b_in = 32'h0064_0000;
        tick();
        expect_outs("capture.grant", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1);
        req = 4'b0000; a_in = 32'h00C8_0000;
        tick();
        expect_outs("capture.ack", 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1);
        tick();
        expect_outs("capture.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Requester 1 holds req through its ack: re-granted, second ack two cycles later.
        req = 4'b0010; a_in = 32'h0000_3200; b_in = 32'h0000_2800;
        tick();
        expect_outs("regrant.gnt1", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("regrant.ack1", 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1);
        a_in = 32'h0000_2800; b_in = 32'h0000_3200;
        tick();
        expect_outs("regrant.gnt2", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
        req = 4'b0000;
        tick();
        expect_outs("regrant.ack2", 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1);
        tick();
        expect_outs("regrant.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset while two comparisons are in the pipe: the pending ack is dropped.
        req = 4'b0011; a_in = 32'h0000_0705; b_in = 32'h0000_0201;
        tick();
        expect_outs("midrst.gnt0", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
        req = 4'b0010;
        tick();
        expect_outs("midrst.gnt1", 4'b0010, 4'b0001, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        expect_outs("midrst.reset", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0; req = 4'b0011;
        tick();
        expect_outs("midrst.post", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
        req = 4'b0010;
        tick();
        expect_outs("midrst.post2", 4'b0010, 4'b0001, 1'b1, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        expect_outs("midrst.post3", 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
